// File: rtl/mem_port_arbiter_if.sv
// Bundles the I/D requester handshakes and the shared memory port of mem_port_arbiter.
// No logic: pure wiring, zero latency.
// Requesters hold req until ack; the memory side has no stall and answers after a fixed latency.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction requester
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   // data requester
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_we;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   // shared memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_i;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_data_en;
   logic              mem_write_en;
   // status
   logic              busy;

   // arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_data_o,
      output i_ack, i_rdata, d_ack, d_rdata,
             mem_addr, mem_data_i, mem_data_en, mem_write_en, busy
   );

   // requesters plus memory side
   modport master (
      output i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_data_o,
      input  i_ack, i_rdata, d_ack, d_rdata,
             mem_addr, mem_data_i, mem_data_en, mem_write_en, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I and D requesters with round-robin grant on contention.
// Latency: request sampled in IDLE at cycle N -> mem strobe at N+1 -> ack at N+2+MEM_LATENCY.
// Backpressure: one transaction at a time; a waiting requester simply holds req until its ack.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state;
   logic       owner_d;  // 1: D owns the in-flight transaction
   logic       last_d;   // 1: last grant went to D
   logic       lat_we;
   logic [2:0] cnt;
   logic       grant_d;

   // D wins when it is alone, or on a tie when I was served last
   assign grant_d = bus.d_req & (~bus.i_req | ~last_d);

   // Arbiter FSM; every output is registered and the mem strobes live only in ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         owner_d          <= 1'b0;
         last_d           <= 1'b0;
         lat_we           <= 1'b0;
         cnt              <= 3'd0;
         bus.i_ack        <= 1'b0;
         bus.d_ack        <= 1'b0;
         bus.i_rdata      <= {DATA_W{1'b0}};
         bus.d_rdata      <= {DATA_W{1'b0}};
         bus.mem_addr     <= {ADDR_W{1'b0}};
         bus.mem_data_i   <= {DATA_W{1'b0}};
         bus.mem_data_en  <= 1'b0;
         bus.mem_write_en <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         // pulses and the memory strobe default low; only the transitions below raise them
         bus.i_ack        <= 1'b0;
         bus.d_ack        <= 1'b0;
         bus.mem_addr     <= {ADDR_W{1'b0}};
         bus.mem_data_i   <= {DATA_W{1'b0}};
         bus.mem_data_en  <= 1'b0;
         bus.mem_write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  // the mem_* registers double as the address/data latch, so the
                  // requester inputs are never looked at again after this grant
                  owner_d          <= grant_d;
                  last_d           <= grant_d;
                  lat_we           <= grant_d & bus.d_we;
                  bus.mem_addr     <= grant_d ? bus.d_addr : bus.i_addr;
                  bus.mem_data_i   <= grant_d ? bus.d_wdata : {DATA_W{1'b0}};
                  bus.mem_write_en <= grant_d & bus.d_we;
                  bus.mem_data_en  <= 1'b1;
                  bus.busy         <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= 3'(MEM_LATENCY - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  if (!lat_we) begin
                     if (owner_d) bus.d_rdata <= bus.mem_data_o;
                     else         bus.i_rdata <= bus.mem_data_o;
                  end
                  bus.d_ack <= owner_d;
                  bus.i_ack <= ~owner_d;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               // no re-grant here: IDLE samples requests on the following cycle
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
